// File: rtl/if_id_fetch.sv
// if_id_fetch: instruction-fetch stage and IF/ID pipeline latch.
//
// Holds a word-addressed instruction memory (IM) and reads it combinationally with the
// incoming PC. The fetched word, the PC and PC+4 are then registered into the IF/ID latch.
// Misaligned or out-of-range fetches return a nop (all zeros) and set addr_err. The
// instruction is still marked valid; the downstream stages decide whether it traps.
//
// Ports:
//   clk         rising-edge clock
//   reset       asynchronous, active-high; clears the latch and the counter, not IM
//   pc_in       current PC from the PC register
//   stall       hold the IF/ID latch
//   flush       load a bubble (wins over stall)
//   im_we       IM write enable (program load; honoured during reset)
//   im_waddr    IM word index to write
//   im_wdata    IM write data
//   instr_out   latched instruction
//   pc_out      latched PC
//   pc4_out     latched PC+4
//   valid_out   latched instruction is real (not a bubble)
//   addr_err    latched fetch was misaligned or out of range
//   fetch_count number of valid instructions accepted into the latch
module if_id_fetch #(
  parameter int unsigned IM_AW     = 10,
  parameter logic [31:0] TEXT_BASE = 32'h0000_3000
) (
  input  logic             clk,
  input  logic             reset,
  input  logic [31:0]      pc_in,
  input  logic             stall,
  input  logic             flush,
  input  logic             im_we,
  input  logic [IM_AW-1:0] im_waddr,
  input  logic [31:0]      im_wdata,
  output logic [31:0]      instr_out,
  output logic [31:0]      pc_out,
  output logic [31:0]      pc4_out,
  output logic             valid_out,
  output logic             addr_err,
  output logic [31:0]      fetch_count
);

  localparam int unsigned ImDepth = 2 ** IM_AW;
  // IM size in bytes, one bit wider than the PC so the compare also works when IM_AW = 30.
  localparam logic [32:0] ImBytes = 33'(4) << IM_AW;

  // Instruction memory. Not reset: a program loaded before or during reset must survive it.
  logic [31:0] im_q [ImDepth];

  always_ff @(posedge clk) begin
    if (im_we) begin
      im_q[im_waddr] <= im_wdata;
    end
  end

  // Combinational fetch
  logic [31:0]      off;
  logic [IM_AW-1:0] idx;
  logic             misaligned;
  logic             out_of_range;
  logic             fetch_err;
  logic [31:0]      fetched;

  always_comb begin
    // A PC below TEXT_BASE wraps to a huge offset and so lands out of range.
    off          = pc_in - TEXT_BASE;
    idx          = off[IM_AW+1:2];
    misaligned   = (pc_in[1:0] != 2'b00);
    out_of_range = ({1'b0, off} >= ImBytes);
    fetch_err    = misaligned | out_of_range;
    fetched      = fetch_err ? 32'h0 : im_q[idx];
  end

  // IF/ID latch
  logic [31:0] instr_q, instr_d;
  logic [31:0] pc_q, pc_d;
  logic [31:0] pc4_q, pc4_d;
  logic        valid_q, valid_d;
  logic        err_q, err_d;
  logic [31:0] count_q, count_d;

  always_comb begin
    instr_d = instr_q;
    pc_d    = pc_q;
    pc4_d   = pc4_q;
    valid_d = valid_q;
    err_d   = err_q;
    count_d = count_q;
    if (flush) begin
      // Bubble: keeps the PC so the next-PC logic still has a sensible link value.
      instr_d = 32'h0;
      pc_d    = pc_in;
      pc4_d   = pc_in + 32'd4;
      valid_d = 1'b0;
      err_d   = 1'b0;
    end else if (!stall) begin
      instr_d = fetched;
      pc_d    = pc_in;
      pc4_d   = pc_in + 32'd4;
      valid_d = 1'b1;
      err_d   = fetch_err;
      count_d = count_q + 32'd1;
    end
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      instr_q <= 32'h0;
      pc_q    <= TEXT_BASE;
      pc4_q   <= TEXT_BASE + 32'd4;
      valid_q <= 1'b0;
      err_q   <= 1'b0;
      count_q <= 32'h0;
    end else begin
      instr_q <= instr_d;
      pc_q    <= pc_d;
      pc4_q   <= pc4_d;
      valid_q <= valid_d;
      err_q   <= err_d;
      count_q <= count_d;
    end
  end

  assign instr_out   = instr_q;
  assign pc_out      = pc_q;
  assign pc4_out     = pc4_q;
  assign valid_out   = valid_q;
  assign addr_err    = err_q;
  assign fetch_count = count_q;

endmodule

// File: tb/tb_if_id_fetch.sv
// Bench for if_id_fetch: directed vectors, a behavioural model of IM and the IF/ID
// latch, a per-cycle compare process, and literal spot checks that pin the model.
module tb_if_id_fetch;

  localparam int unsigned AW   = 10;
  localparam int unsigned DEP  = 1 << AW;
  localparam logic [31:0] BASE = 32'h0000_3000;

  logic          clk = 1'b0;
  logic          reset;
  logic [31:0]   pc_in;
  logic          stall;
  logic          flush;
  logic          im_we;
  logic [AW-1:0] im_waddr;
  logic [31:0]   im_wdata;
  logic [31:0]   instr_out;
  logic [31:0]   pc_out;
  logic [31:0]   pc4_out;
  logic          valid_out;
  logic          addr_err;
  logic [31:0]   fetch_count;

  if_id_fetch #(
    .IM_AW    (AW),
    .TEXT_BASE(BASE)
  ) dut (
    .clk        (clk),
    .reset      (reset),
    .pc_in      (pc_in),
    .stall      (stall),
    .flush      (flush),
    .im_we      (im_we),
    .im_waddr   (im_waddr),
    .im_wdata   (im_wdata),
    .instr_out  (instr_out),
    .pc_out     (pc_out),
    .pc4_out    (pc4_out),
    .valid_out  (valid_out),
    .addr_err   (addr_err),
    .fetch_count(fetch_count)
  );

  always #5 clk = ~clk;

  int checks = 0;
  int errors = 0;
  bit chk_en = 1'b0;

  // Model state
  logic [31:0] im_m [DEP];
  logic [31:0] m_instr, m_pc, m_pc4, m_count;
  logic        m_valid, m_err;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %h expected %h at %0t", name, act, exp, $time);
    end
  endtask

  task automatic model_reset();
    m_instr = 32'h0;
    m_pc    = BASE;
    m_pc4   = BASE + 32'd4;
    m_valid = 1'b0;
    m_err   = 1'b0;
    m_count = 32'h0;
  endtask

  // What one rising edge does, stated directly from the fetch rules.
  task automatic model_edge();
    longint unsigned offset;
    bit              bad;
    logic [31:0]     word;
    offset = longint'(pc_in) - longint'(BASE);
    if (offset < 0) offset = offset + 64'h1_0000_0000;
    bad  = (pc_in % 4 != 0) || (offset >= 4 * DEP);
    word = bad ? 32'h0 : im_m[offset / 4];
    if (!reset) begin
      if (flush) begin
        m_instr = 32'h0;
        m_pc    = pc_in;
        m_pc4   = pc_in + 32'd4;
        m_valid = 1'b0;
        m_err   = 1'b0;
      end else if (!stall) begin
        m_instr = word;
        m_pc    = pc_in;
        m_pc4   = pc_in + 32'd4;
        m_valid = 1'b1;
        m_err   = bad;
        m_count = m_count + 32'd1;
      end
    end
    if (im_we) im_m[im_waddr] = im_wdata;
  endtask

  // Per-cycle compare against the model, away from the active edge.
  always @(negedge clk) begin
    if (chk_en) begin
      chk("instr_out", instr_out, m_instr);
      chk("pc_out", pc_out, m_pc);
      chk("pc4_out", pc4_out, m_pc4);
      chk("valid_out", {31'h0, valid_out}, {31'h0, m_valid});
      chk("addr_err", {31'h0, addr_err}, {31'h0, m_err});
      chk("fetch_count", fetch_count, m_count);
    end
  end

  task automatic cyc(input logic [31:0] pc, input logic st, input logic fl,
                     input logic we, input logic [AW-1:0] wa, input logic [31:0] wd);
    pc_in    = pc;
    stall    = st;
    flush    = fl;
    im_we    = we;
    im_waddr = wa;
    im_wdata = wd;
    @(posedge clk);
    model_edge();
    @(negedge clk);
    #1;
  endtask

  task automatic fetch(input logic [31:0] pc);
    cyc(pc, 1'b0, 1'b0, 1'b0, '0, 32'h0);
  endtask

  logic [31:0] prog [8];

  initial begin
    prog[0] = 32'h3C01_0001; prog[1] = 32'h3421_0002;
    prog[2] = 32'h0022_1820; prog[3] = 32'hAC03_0000;
    prog[4] = 32'h8C04_0000; prog[5] = 32'h1000_FFFF;
    prog[6] = 32'h0000_0000; prog[7] = 32'h2402_000A;
    for (int i = 0; i < DEP; i++) im_m[i] = 32'h0;

    reset = 1'b1; pc_in = BASE; stall = 1'b0; flush = 1'b0;
    im_we = 1'b0; im_waddr = '0; im_wdata = 32'h0;
    model_reset();
    #1;
    chk_en = 1'b1;
    chk("rst_pc_lit", pc_out, 32'h0000_3000);
    chk("rst_pc4_lit", pc4_out, 32'h0000_3004);

    // Program load while reset is held.
    for (int i = 0; i < 8; i++) cyc(BASE, 1'b0, 1'b0, 1'b1, AW'(i), prog[i]);
    cyc(BASE, 1'b0, 1'b0, 1'b1, AW'(DEP - 1), 32'hDEAD_BEEF);
    im_we = 1'b0;
    reset = 1'b0;

    // 1: basic fetch
    fetch(32'h3000);
    chk("t1_instr_lit", instr_out, 32'h3C01_0001);
    chk("t1_pc_lit", pc_out, 32'h0000_3000);
    chk("t1_pc4_lit", pc4_out, 32'h0000_3004);
    chk("t1_valid_lit", {31'h0, valid_out}, 32'h1);
    fetch(32'h3004);
    chk("t1_instr2_lit", instr_out, 32'h3421_0002);
    chk("t1_count_lit", fetch_count, 32'd2);

    // 2: stall while pc_in moves
    cyc(32'h3008, 1'b1, 1'b0, 1'b0, '0, 32'h0);
    cyc(32'h300C, 1'b1, 1'b0, 1'b0, '0, 32'h0);
    cyc(32'h3010, 1'b1, 1'b0, 1'b0, '0, 32'h0);
    chk("t2_hold_instr_lit", instr_out, 32'h3421_0002);
    chk("t2_hold_count_lit", fetch_count, 32'd2);
    fetch(32'h3010);
    chk("t2_release_lit", instr_out, 32'h8C04_0000);

    // 3: flush beats stall
    cyc(32'h3008, 1'b1, 1'b1, 1'b0, '0, 32'h0);
    chk("t3_instr_lit", instr_out, 32'h0);
    chk("t3_valid_lit", {31'h0, valid_out}, 32'h0);
    chk("t3_pc_lit", pc_out, 32'h0000_3008);
    chk("t3_count_lit", fetch_count, 32'd3);

    // 4: address errors, plus the last in-range word
    fetch(32'h3002);
    chk("t4_mis_err_lit", {31'h0, addr_err}, 32'h1);
    chk("t4_mis_instr_lit", instr_out, 32'h0);
    fetch(32'h4000);
    chk("t4_hi_err_lit", {31'h0, addr_err}, 32'h1);
    fetch(32'h2FFC);
    chk("t4_lo_err_lit", {31'h0, addr_err}, 32'h1);
    chk("t4_lo_valid_lit", {31'h0, valid_out}, 32'h1);
    chk("t4_count_lit", fetch_count, 32'd6);
    fetch(32'h3FFC);
    chk("t4_top_instr_lit", instr_out, 32'hDEAD_BEEF);
    chk("t4_top_err_lit", {31'h0, addr_err}, 32'h0);

    // 5: write and read the same word in one cycle
    cyc(32'h3008, 1'b0, 1'b0, 1'b1, AW'(2), 32'hAAAA_0000);
    chk("t5_old_lit", instr_out, 32'h0022_1820);
    fetch(32'h3008);
    chk("t5_new_lit", instr_out, 32'hAAAA_0000);

    // 6: asynchronous reset mid-cycle after 5 fetches
    for (int i = 0; i < 5; i++) fetch(BASE + 32'(4 * i));
    #2;
    reset = 1'b1;
    model_reset();
    #1;
    chk("t6_valid_lit", {31'h0, valid_out}, 32'h0);
    chk("t6_pc_lit", pc_out, 32'h0000_3000);
    chk("t6_count_lit", fetch_count, 32'd0);
    @(posedge clk);
    model_edge();
    @(negedge clk);
    #1;
    reset = 1'b0;
    fetch(32'h3000);
    chk("t6_refetch_lit", instr_out, 32'h3C01_0001);
    fetch(32'h3004);
    chk("t6_refetch2_lit", instr_out, 32'h3421_0002);
    chk("t6_count2_lit", fetch_count, 32'd2);

    chk_en = 1'b0;
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
